// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types, constants and the arbitration helper that
// mem_port_arbiter uses.
//   arb_state_e : FSM encoding (IDLE / ISSUE / RESP)
//   REQ_I/REQ_D : requester IDs, also the value carried on `grant`
//   arb_winner  : picks the requester to serve next from the two requests
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // A single requester always wins. On a tie, round-robin hands the port
    // to whoever was not granted last; otherwise the load/store side wins.
    function automatic logic arb_winner(
        input logic i_req_s,
        input logic d_req_s,
        input logic owner_s,
        input logic rr_en_s
    );
        logic win_s;
        if (i_req_s && d_req_s) begin
            if (rr_en_s) begin
                win_s = ~owner_s;
            end else begin
                win_s = REQ_D;
            end
        end else if (d_req_s) begin
            win_s = REQ_D;
        end else begin
            win_s = REQ_I;
        end
        return win_s;
    endfunction

endpackage

// File: rtl/Mux2_32.sv
// Mux2_32: 32-bit two-input multiplexer shared by the address and
// write-data paths of the memory port.
//   sel_i : 0 selects a_i, 1 selects b_i
//   a_i   : input 0
//   b_i   : input 1
//   y_o   : selected value
module Mux2_32 (
    input  logic        sel_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single 32-bit memory port between the
// instruction-fetch requester (I) and the load/store requester (D). One
// transaction is in flight at a time: IDLE -> ISSUE -> RESP -> IDLE.
//
// Parameter:
//   TIMEOUT : max ISSUE cycles without mem_ready before the owner gets an
//             error response; 0 waits forever.
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN : when defined, ties alternate between I and D;
//                            when undefined, D always wins ties.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   i_req/i_addr                 : fetch request, held until i_ack
//   i_ack/i_err/i_rdata          : fetch response (one-cycle strobe)
//   d_req/d_we/d_addr/d_wdata    : load/store request, held until d_ack
//   d_ack/d_err/d_rdata          : load/store response (one-cycle strobe)
//   mem_req/mem_we/mem_addr/mem_wdata : memory request, held until mem_ready
//   mem_ready/mem_rdata          : memory completion and read data
//   grant                        : current owner (0 = I, 1 = D)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        grant
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] RESP  = ST_RESP;

    // A zero TIMEOUT still needs a legal (unused) one-bit counter.
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic          TO_EN    = (TIMEOUT > 0) ? 1'b1 : 1'b0;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    logic [1:0]    state_q, state_d;
    logic          grant_q, grant_d;
    logic          owner_q, owner_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic          winner_s;
    logic          timeout_s;
    logic          issue_s;
    logic          resp_s;
    logic [31:0]   addr_mux_s;
    logic [31:0]   wdata_mux_s;

    // With round-robin off, RR_EN masks owner_q inside the helper.
    assign winner_s  = arb_winner(i_req, d_req, owner_q, RR_EN);
    assign timeout_s = TO_EN & (cnt_q == CNT_LAST);
    assign issue_s   = (state_q == ISSUE);
    assign resp_s    = (state_q == RESP);

    // The fetch side never writes, so its write-data leg is tied to zero.
    Mux2_32 u_addr_mux (
        .sel_i (grant_q),
        .a_i   (i_addr),
        .b_i   (d_addr),
        .y_o   (addr_mux_s)
    );

    Mux2_32 u_wdata_mux (
        .sel_i (grant_q),
        .a_i   (32'h0000_0000),
        .b_i   (d_wdata),
        .y_o   (wdata_mux_s)
    );

    // Next-state logic for FSM, grant/owner, wait counter and response data.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_d = winner_s;
                    owner_d = winner_s;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // A completion in the last allowed cycle beats the timeout.
                if (mem_ready) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (grant_q == REQ_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                end else if (timeout_s) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (grant_q == REQ_D) begin
                        d_rdata_d = 32'h0000_0000;
                    end else begin
                        i_rdata_d = 32'h0000_0000;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; owner resets to D so round-robin favours I first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= REQ_I;
            owner_q   <= REQ_D;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            i_rdata_q <= 32'h0000_0000;
            d_rdata_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Memory-side outputs are gated by ISSUE so they read zero otherwise.
    assign mem_req   = issue_s;
    assign mem_we    = issue_s & grant_q & d_we;
    assign mem_addr  = issue_s ? addr_mux_s  : 32'h0000_0000;
    assign mem_wdata = issue_s ? wdata_mux_s : 32'h0000_0000;
    assign grant     = grant_q;

    assign i_ack   = resp_s & ~grant_q;
    assign d_ack   = resp_s & grant_q;
    assign i_err   = i_ack & err_q;
    assign d_err   = d_ack & err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
